// File: rtl/sat_clip_pkg.sv
// Shared types, default geometry and clamp-bound helpers for the sat_clip_unit narrowing clip pipeline.
package sat_clip_pkg;

  typedef enum logic [1:0] {
    RM_RNU = 2'd0,
    RM_RNE = 2'd1,
    RM_RDN = 2'd2,
    RM_ROD = 2'd3
  } rm_e;

  localparam int W_IN_DEF  = 16;
  localparam int W_OUT_DEF = 8;
  localparam int LANES_DEF = 4;

  function automatic int smax(input int w);
    return (32'sd1 <<< (w - 32'sd1)) - 32'sd1;
  endfunction

  function automatic int smin(input int w);
    return -(32'sd1 <<< (w - 32'sd1));
  endfunction

  function automatic int umax(input int w);
    return (32'sd1 <<< w) - 32'sd1;
  endfunction

  localparam int SMAX_DEF = smax(W_OUT_DEF);
  localparam int SMIN_DEF = smin(W_OUT_DEF);
  localparam int UMAX_DEF = umax(W_OUT_DEF);

endpackage

// File: rtl/sat_clip_if.sv
// Beat-level handshake, sideband and status bundle between an issuing stage and sat_clip_unit.
interface sat_clip_if
  import sat_clip_pkg::*;
#(
  parameter int W_IN    = W_IN_DEF,
  parameter int W_OUT   = W_OUT_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int SHAMT_W = $clog2(W_IN)
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*W_IN-1:0]    in_data;
  logic [SHAMT_W-1:0]       in_shamt;
  logic [1:0]               in_rm;
  logic                     in_signed;
  logic [LANES-1:0]         in_mask;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*W_OUT-1:0]   out_data;
  logic [LANES-1:0]         out_sat;
  logic                     sat_flag;
  logic                     sat_clr;

  modport master (
    output in_valid, in_data, in_shamt, in_rm, in_signed, in_mask, out_ready, sat_clr,
    input  in_ready, out_valid, out_data, out_sat, sat_flag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_rm, in_signed, in_mask, out_ready, sat_clr,
    output in_ready, out_valid, out_data, out_sat, sat_flag
  );

endinterface

// File: rtl/sat_clip_round.sv
// Per-lane right shift plus fixed-point rounding increment, producing a W_IN+1 bit sum that cannot wrap.
// Rounding modes exist only when SAT_CLIP_ROUND_EN is defined; otherwise the lane truncates.
module sat_clip_round
  import sat_clip_pkg::*;
#(
  parameter int W_IN    = W_IN_DEF,
  parameter int SHAMT_W = $clog2(W_IN)
) (
  input  logic [W_IN-1:0]    v,
  input  logic [SHAMT_W-1:0] d,
  input  logic [1:0]         rm,
  input  logic               is_signed,
  output logic [W_IN:0]      sum
);

  logic [W_IN:0] ext;
  logic [W_IN:0] shifted;
  logic          r;

  assign ext     = {is_signed & v[W_IN-1], v};
  assign shifted = $signed(ext) >>> d;

`ifdef SAT_CLIP_ROUND_EN
  localparam logic [W_IN-1:0]    ONE   = {{(W_IN-1){1'b0}}, 1'b1};
  localparam logic [SHAMT_W-1:0] D_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  logic            bit_d;
  logic            bit_dm1;
  logic [W_IN-1:0] mask_d;
  logic [W_IN-1:0] mask_dm1;

  // bit_d is the shifted LSB; bit_dm1 the first discarded bit; masks select the discarded tails
  assign bit_d  = v[d];
  assign mask_d = (ONE << d) - ONE;

  // Rounding increment; a zero shift discards nothing, so every mode adds 0
  always_comb begin
    bit_dm1  = 1'b0;
    mask_dm1 = {W_IN{1'b0}};
    r        = 1'b0;
    if (d != {SHAMT_W{1'b0}}) begin
      bit_dm1  = v[d - D_ONE];
      mask_dm1 = (ONE << (d - D_ONE)) - ONE;
    end else begin
      bit_dm1  = 1'b0;
      mask_dm1 = {W_IN{1'b0}};
    end
    case (rm_e'(rm))
      RM_RNU:  r = bit_dm1;
      RM_RNE:  r = bit_dm1 & ((|(v & mask_dm1)) | bit_d);
      RM_RDN:  r = 1'b0;
      RM_ROD:  r = ~bit_d & (|(v & mask_d));
      default: r = 1'b0;
    endcase
  end
`else
  logic unused_rm;

  assign unused_rm = ^rm;
  assign r         = 1'b0;
`endif

  assign sum = shifted + {{W_IN{1'b0}}, r};

endmodule

// File: rtl/sat_clip_unit.sv
// Two-stage multi-lane narrowing clip (vnclip/vnclipu style) with sticky saturation flag.
// Optional rounding modes are enabled by defining SAT_CLIP_ROUND_EN; without it every beat truncates.
module sat_clip_unit
  import sat_clip_pkg::*;
#(
  parameter int W_IN    = W_IN_DEF,
  parameter int W_OUT   = W_OUT_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int SHAMT_W = $clog2(W_IN)
) (
  input  logic    clk,
  input  logic    rst,
  sat_clip_if.slave bus
);

  localparam int SW = W_IN + 1;
  localparam logic signed [SW-1:0] SMAX = SW'(smax(W_OUT));
  localparam logic signed [SW-1:0] SMIN = SW'(smin(W_OUT));
  localparam logic signed [SW-1:0] UMAX = SW'(umax(W_OUT));

  logic signed [SW-1:0]     rnd_sum [LANES];
  logic signed [SW-1:0]     s1_sum  [LANES];
  logic                     s1_valid;
  logic                     s1_signed;
  logic [LANES-1:0]         s1_mask;
  logic                     s2_valid;
  logic [LANES*W_OUT-1:0]   s2_data;
  logic [LANES-1:0]         s2_sat;
  logic                     sat_sticky;
  logic                     s2_free;
  logic                     s1_advance;
  logic                     in_accept;
  logic [LANES*W_OUT-1:0]   clip_data;
  logic [LANES-1:0]         clip_sat;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sat_clip_round #(
      .W_IN    (W_IN),
      .SHAMT_W (SHAMT_W)
    ) u_round (
      .v         (bus.in_data[i*W_IN +: W_IN]),
      .d         (bus.in_shamt),
      .rm        (bus.in_rm),
      .is_signed (bus.in_signed),
      .sum       (rnd_sum[i])
    );
  end

  assign s2_free    = ~s2_valid | bus.out_ready;
  assign s1_advance = s1_valid & s2_free;
  assign bus.in_ready = ~s1_valid | s1_advance;
  assign in_accept  = bus.in_valid & bus.in_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_sat   = s2_sat;
  assign bus.sat_flag  = sat_sticky;

  // Stage-2 clamp of the widened sums; masked lanes are forced to zero without flagging
  always_comb begin
    clip_data = {(LANES*W_OUT){1'b0}};
    clip_sat  = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (!s1_mask[i]) begin
        clip_data[i*W_OUT +: W_OUT] = {W_OUT{1'b0}};
        clip_sat[i]                 = 1'b0;
      end else if (s1_signed) begin
        if (s1_sum[i] > SMAX) begin
          clip_data[i*W_OUT +: W_OUT] = SMAX[W_OUT-1:0];
          clip_sat[i]                 = 1'b1;
        end else if (s1_sum[i] < SMIN) begin
          clip_data[i*W_OUT +: W_OUT] = SMIN[W_OUT-1:0];
          clip_sat[i]                 = 1'b1;
        end else begin
          clip_data[i*W_OUT +: W_OUT] = s1_sum[i][W_OUT-1:0];
          clip_sat[i]                 = 1'b0;
        end
      end else begin
        // unsigned sums are zero-extended, so only the upper bound can be crossed
        if (s1_sum[i] > UMAX) begin
          clip_data[i*W_OUT +: W_OUT] = UMAX[W_OUT-1:0];
          clip_sat[i]                 = 1'b1;
        end else begin
          clip_data[i*W_OUT +: W_OUT] = s1_sum[i][W_OUT-1:0];
          clip_sat[i]                 = 1'b0;
        end
      end
    end
  end

  // Stage-1 register: rounded sums plus the sideband needed by the clamp
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_signed <= 1'b0;
      s1_mask   <= {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) begin
        s1_sum[i] <= {SW{1'b0}};
      end
    end else if (in_accept) begin
      s1_valid  <= 1'b1;
      s1_signed <= bus.in_signed;
      s1_mask   <= bus.in_mask;
      s1_sum    <= rnd_sum;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage-2 register drives the outputs and holds them while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= {(LANES*W_OUT){1'b0}};
      s2_sat   <= {LANES{1'b0}};
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= clip_data;
        s2_sat  <= clip_sat;
      end
    end
  end

  // Sticky flag: an accepted saturating beat outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_sticky <= 1'b0;
    end else if (s2_valid & bus.out_ready & (|s2_sat)) begin
      sat_sticky <= 1'b1;
    end else if (bus.sat_clr) begin
      sat_sticky <= 1'b0;
    end
  end

endmodule
